collatz_sweep: RTL
==================

Name: collatz_sweep

Overview:
- Sequencer that sits directly upstream of the range block and also consumes its results.
- Accepts a sweep command: a base number plus a window count.
- For each window it pulses range's go with start = window base and waits for done. It then walks start over addresses 0..RAM_WORDS-1 to read each stored count.
- Streams every (n, count) pair out on a valid/ready port and tracks the sweep-wide maximum count and the n that produced it.

Parameters:
- RAM_WORDS, 16, counts per window; must match the attached range instance.
- RAM_ADDR_BITS, 4, log2(RAM_WORDS).
- TIMEOUT_CYCLES, 65535, done-wait limit; used only with COLLATZ_SWEEP_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  sweep command present
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  32  first n of the sweep
- cmd_windows  in  16  number of RAM_WORDS-sized windows
- r_go  out  1  to range go
- r_start  out  32  to range start (start value, then read address)
- r_done  in  1  from range done
- r_count  in  16  from range count (combinational mem[start] while done)
- res_valid  out  1  result pair valid
- res_ready  in  1  downstream accepts
- res_n  out  32  n of the result
- res_count  out  16  iteration count of res_n
- max_n  out  32  n with the largest count so far this sweep
- max_count  out  16  largest count so far this sweep
- busy  out  1  not IDLE
- sweep_done  out  1  one-cycle pulse at sweep end
- timeout  out  1  sticky error flag; constant 0 unless the watchdog is compiled in

Behaviour:
- Reset is asynchronous and active-low. Every register clears, and every output resets to 0 except cmd_ready, which is 1.
- Reset asserted mid-sweep aborts the sweep immediately: r_go drops to 0 and no sweep_done is generated.
- States:
  - IDLE: cmd_ready=1. When cmd_valid is high, latch base=cmd_base and windows=cmd_windows, clear max_n/max_count/timeout, and set win=0, idx=0.
    - If cmd_windows==0, go to FINISH.
    - Otherwise go to GO.
  - GO: r_go=1 for exactly one cycle, with r_start=base. Next state is ARM.
  - ARM: r_go=0. Wait one cycle, because range's done stays stale for one cycle after go. Next state is WAIT.
  - WAIT: stay until r_done==1. During WAIT, r_start already holds idx zero-extended to 32 bits. Next state is READ.
  - READ: sample r_count, which is valid this cycle because r_start was stable a cycle earlier.
    - Load res_n=base+idx (mod 2^32) and res_count=r_count.
    - If r_count > max_count (strictly greater), update max_count and max_n. Ties keep the earlier, smaller-index n.
    - Next state is EMIT.
  - EMIT: res_valid=1, and res_n/res_count are held stable until res_ready is high.
    - On handshake with idx<RAM_WORDS-1: idx++, update r_start, go to READ.
    - On handshake with idx==RAM_WORDS-1 and win<windows-1: win++, base+=RAM_WORDS (mod 2^32), idx=0, go to GO.
    - Otherwise go to FINISH.
  - FINISH: sweep_done=1 for one cycle, then IDLE. max_n/max_count hold until the next command.
- Every result within a window costs 2 cycles minimum (READ+EMIT), so the stream runs at 1 result per 2 cycles at best.
- res_valid never drops without a handshake. Backpressure can stall EMIT indefinitely with no loss.
- cmd_valid is ignored outside IDLE.
- Base wraparound past 2^32-1 wraps silently. res_n and max_n use the wrapped value.
- r_go is never high outside GO.

Optional Feature:
- Macro: COLLATZ_SWEEP_WATCHDOG_EN.
- With the macro:
  - A 32-bit counter clears on entry to ARM and counts in WAIT.
  - Once it reaches TIMEOUT_CYCLES without r_done, the block sets timeout=1 (sticky until the next command), skips the window's reads and emits nothing for that window.
  - It then continues with the next window exactly as on the last-index EMIT handshake. This covers n=0, which never converges.
- Without the macro: no counter is built, timeout is tied 0, and WAIT waits forever.

Test Plan:
- Reset, then cmd base=1, windows=1, stub range with counts[i]=i+3, res_ready=1 → 16 results n=1..16 with count 3..18, max_n=16, max_count=18, one sweep_done, r_go pulsed once.
- Stub with counts all 5, base=100, windows=2 → 32 results n=100..131, max_n=100 (tie keeps first), r_start=100 then 116 on the two go pulses.
- res_ready toggling 1-in-3 → res_n/res_count stable while res_valid && !res_ready, no duplicate or missing n, still 16 results.
- cmd_windows=0 → sweep_done on the second cycle after acceptance, no r_go, max_count=0.
- base=32'hFFFFFFF8, windows=1 → res_n runs FFFFFFF8..FFFFFFFF then 0..7.
- reset_n low during EMIT of idx 7 → all outputs 0 asynchronously, cmd_ready=1 after release.
- With COLLATZ_SWEEP_WATCHDOG_EN and TIMEOUT_CYCLES=50: stub never asserts done in window 0 but does in window 1 → timeout=1, only window 1's 16 results emitted, then sweep_done.

Source files
------------

// File: rtl/collatz_sweep.sv
// Sweep sequencer for the collatz range block: runs windows, reads back counts, streams (n, count) and tracks the sweep max.
// Optional done-wait watchdog: define COLLATZ_SWEEP_WATCHDOG_EN.
module collatz_sweep #(
    parameter int unsigned RAM_WORDS      = 16,
    parameter int unsigned RAM_ADDR_BITS  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_base,
    input  logic [15:0] cmd_windows,
    output logic        r_go,
    output logic [31:0] r_start,
    input  logic        r_done,
    input  logic [15:0] r_count,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_n,
    output logic [15:0] res_count,
    output logic [31:0] max_n,
    output logic [15:0] max_count,
    output logic        busy,
    output logic        sweep_done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_ARM,
        S_WAIT,
        S_READ,
        S_EMIT,
        S_FINISH
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX   = RAM_ADDR_BITS'(RAM_WORDS - 1);
    localparam logic [31:0]              WIN_STRIDE = 32'(RAM_WORDS);

    state_t                   state;
    logic [31:0]              base;
    logic [15:0]              windows;
    logic [15:0]              win;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic                     last_win;

    assign last_win = (win == windows - 16'd1);

`ifdef COLLATZ_SWEEP_WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        timeout_q;

    assign timeout = timeout_q;
`else
    // Watchdog not built: the limit only matters when it is.
    logic unused_tmo;

    assign timeout    = 1'b0;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            base       <= '0;
            windows    <= '0;
            win        <= '0;
            idx        <= '0;
            cmd_ready  <= 1'b1;
            r_go       <= 1'b0;
            r_start    <= '0;
            res_valid  <= 1'b0;
            res_n      <= '0;
            res_count  <= '0;
            max_n      <= '0;
            max_count  <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
            wd_cnt     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            r_go       <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        base      <= cmd_base;
                        windows   <= cmd_windows;
                        win       <= '0;
                        idx       <= '0;
                        max_n     <= '0;
                        max_count <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
                        timeout_q <= 1'b0;
`endif
                        if (cmd_windows == 16'd0) begin
                            state      <= S_FINISH;
                            sweep_done <= 1'b1;
                        end else begin
                            state   <= S_GO;
                            r_go    <= 1'b1;
                            r_start <= cmd_base;
                        end
                    end
                end
                S_GO: begin
                    // Range has latched start; from here on r_start is the read address.
                    state   <= S_ARM;
                    r_start <= 32'(idx);
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
                    wd_cnt  <= '0;
`endif
                end
                S_ARM: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_done) begin
                        state <= S_READ;
                    end
`ifdef COLLATZ_SWEEP_WATCHDOG_EN
                    else if (wd_cnt >= 32'(TIMEOUT_CYCLES)) begin
                        // Give up on this window and move on as if its last result was taken.
                        timeout_q <= 1'b1;
                        if (!last_win) begin
                            win     <= win + 16'd1;
                            base    <= base + WIN_STRIDE;
                            idx     <= '0;
                            state   <= S_GO;
                            r_go    <= 1'b1;
                            r_start <= base + WIN_STRIDE;
                        end else begin
                            state      <= S_FINISH;
                            sweep_done <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end
                S_READ: begin
                    res_n     <= base + 32'(idx);
                    res_count <= r_count;
                    res_valid <= 1'b1;
                    if (r_count > max_count) begin
                        max_count <= r_count;
                        max_n     <= base + 32'(idx);
                    end
                    state <= S_EMIT;
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (idx != LAST_IDX) begin
                            idx     <= idx + 1'b1;
                            r_start <= 32'(idx) + 32'd1;
                            state   <= S_READ;
                        end else if (!last_win) begin
                            win     <= win + 16'd1;
                            base    <= base + WIN_STRIDE;
                            idx     <= '0;
                            state   <= S_GO;
                            r_go    <= 1'b1;
                            r_start <= base + WIN_STRIDE;
                        end else begin
                            state      <= S_FINISH;
                            sweep_done <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
